// File: rtl/err_grant_servicer.sv
// Sticky error capture around the priority encoder and valid/ready servicing of its grant.
// Optional handler timeout with to_flag output: define ERR_SERVICE_TIMEOUT_EN.
module err_grant_servicer #(
  parameter int N           = 32,
  parameter int IDXW        = $clog2(N),
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    err_raw,
  output logic [N-1:0]    err_pend,
  input  logic [N-1:0]    err_sel,
  output logic            irq_valid,
  output logic [IDXW-1:0] irq_idx,
  input  logic            irq_ready,
  input  logic            clr_all,
  output logic            sel_err,
  output logic [7:0]      drop_cnt,
`ifdef ERR_SERVICE_TIMEOUT_EN
  output logic            to_flag,
`endif
  output logic            busy
);

  localparam int CW = $clog2(SETTLE_CYC + 1);

  if (SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("err_grant_servicer: SETTLE_CYC and TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    SETTLE
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sel_err_q, sel_err_d;
  logic [7:0]      drop_q, drop_d;
  logic [N-1:0]    clr_vec;
  logic            sel_multi;
  logic            sel_one;
  logic [IDXW-1:0] sel_idx;

`ifdef ERR_SERVICE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          to_q, to_d;
`endif

  always_comb begin
    sel_multi = (err_sel & (err_sel - N'(1))) != '0;
    sel_one   = (err_sel != '0) && !sel_multi;
    sel_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (err_sel[i]) sel_idx = IDXW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sel_err_d = sel_err_q;
    clr_vec   = '0;
`ifdef ERR_SERVICE_TIMEOUT_EN
    timer_d   = '0;
    to_d      = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sel_multi) begin
          sel_err_d = 1'b1;
        end else if (sel_one && ((err_sel & pend_q) != '0)) begin
          idx_d   = sel_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ready) begin
          clr_vec = N'(1) << idx_q;
          state_d = SETTLE;
          cnt_d   = CW'(SETTLE_CYC - 1);
        end
`ifdef ERR_SERVICE_TIMEOUT_EN
        // Withdraw without clearing so the error is granted again later
        else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = SETTLE;
          cnt_d   = CW'(SETTLE_CYC - 1);
          to_d    = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (clr_all) begin
      clr_vec = '1;
      state_d = IDLE;
    end
    pend_d = (pend_q & ~clr_vec) | err_raw;
    drop_d = drop_q;
    if (((err_raw & pend_q & ~clr_vec) != '0) && (drop_q != 8'hff))
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      sel_err_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sel_err_q <= sel_err_d;
      drop_q    <= drop_d;
    end
  end

`ifdef ERR_SERVICE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      to_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      to_q    <= to_d;
    end
  end

  assign to_flag = to_q;
`endif

  assign err_pend  = pend_q;
  assign irq_valid = (state_q == PRESENT);
  assign irq_idx   = idx_q;
  assign sel_err   = sel_err_q;
  assign drop_cnt  = drop_q;
  assign busy      = (state_q != IDLE);

endmodule
